// File: rtl/id_hazard_unit_pkg.sv
// Shared RV32 opcode constants, hazard FSM encoding and source-register usage helpers
// for the ID-stage hazard unit.
package id_hazard_unit_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_HOLD = 1'b1
    } hz_state_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH || opcode == OPC_STORE || opcode == OPC_OP);
    endfunction

endpackage

// File: rtl/id_hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle. stall_cycles exists only with HAZARD_STATS_EN.
// There is no valid/ready handshake: every signal is level-sampled each cycle.
interface id_hazard_unit_if;
    logic [6:0]  ID_Opcode;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_BranchTaken;
    logic        EX_MemRead;
    logic        EX_RegWrite;
    logic [4:0]  EX_rd;
    logic        MEM_WBSrc;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_rd;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
`ifdef HAZARD_STATS_EN
        input  stall_cycles,
`endif
        output ID_Opcode, ID_rs1, ID_rs2, ID_BranchTaken,
        output EX_MemRead, EX_RegWrite, EX_rd,
        output MEM_WBSrc, MEM_RegWrite, MEM_rd,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush
    );

    modport slave (
`ifdef HAZARD_STATS_EN
        output stall_cycles,
`endif
        input  ID_Opcode, ID_rs1, ID_rs2, ID_BranchTaken,
        input  EX_MemRead, EX_RegWrite, EX_rd,
        input  MEM_WBSrc, MEM_RegWrite, MEM_rd,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush
    );
endinterface

// File: rtl/id_hazard_unit_detect.sv
// Combinational hazard detection: per-source producer matches reduced to a stall need
// of 0, 1 or 2 cycles.
module id_hazard_detect
    import id_hazard_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       mem_wb_src,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    output logic [1:0] need
);

    // A branch compares in ID, so it also waits on ALU results still in EX and on
    // loads still in MEM; other instructions only wait on a load in EX.
    function automatic logic [1:0] src_need(
        input logic       is_branch,
        input logic [4:0] src,
        input logic       ex_mr,
        input logic       ex_rw,
        input logic [4:0] ex_dst,
        input logic       mem_ld,
        input logic       mem_rw,
        input logic [4:0] mem_dst
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = (src == ex_dst) && (ex_dst != 5'd0);
        mem_hit = (src == mem_dst) && (mem_dst != 5'd0);
        if (is_branch && ex_hit && ex_mr)               return 2'd2;
        if (is_branch && ex_hit && ex_rw && !ex_mr)     return 2'd1;
        if (is_branch && mem_hit && mem_rw && mem_ld)   return 2'd1;
        if (!is_branch && ex_hit && ex_mr)              return 2'd1;
        return 2'd0;
    endfunction

    logic       is_branch;
    logic [1:0] need_rs1;
    logic [1:0] need_rs2;

    always_comb begin
        is_branch = (opcode == OPC_BRANCH);
        need_rs1  = 2'd0;
        need_rs2  = 2'd0;
        if (uses_rs1(opcode))
            need_rs1 = src_need(is_branch, rs1, ex_mem_read, ex_reg_write, ex_rd,
                                mem_wb_src, mem_reg_write, mem_rd);
        if (uses_rs2(opcode))
            need_rs2 = src_need(is_branch, rs2, ex_mem_read, ex_reg_write, ex_rd,
                                mem_wb_src, mem_reg_write, mem_rd);
        need = (need_rs1 > need_rs2) ? need_rs1 : need_rs2;
    end

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage hazard/stall controller: RUN/HOLD FSM, stall counter and pipeline enables.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module id_hazard_unit
    import id_hazard_unit_pkg::*;
#(
    parameter int STALL_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    id_hazard_unit_if.slave   hz,
    output hz_state_t         dbg_state
);

    localparam int CW = $clog2(STALL_MAX + 1);

    hz_state_t     state_q;
    hz_state_t     state_d;
    logic [CW-1:0] rem_q;
    logic [CW-1:0] rem_d;
    logic [1:0]    need;
    logic          stall;

    id_hazard_detect u_detect (
        .opcode        (hz.ID_Opcode),
        .rs1           (hz.ID_rs1),
        .rs2           (hz.ID_rs2),
        .ex_mem_read   (hz.EX_MemRead),
        .ex_reg_write  (hz.EX_RegWrite),
        .ex_rd         (hz.EX_rd),
        .mem_wb_src    (hz.MEM_WBSrc),
        .mem_reg_write (hz.MEM_RegWrite),
        .mem_rd        (hz.MEM_rd),
        .need          (need)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // rem counts the HOLD cycles still owed after the RUN cycle that detected the hazard.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            HZ_RUN: begin
                if (need == 2'd2) begin
                    state_d = HZ_HOLD;
                    rem_d   = CW'(need - 2'd1);
                end
            end
            HZ_HOLD: begin
                rem_d = rem_q - CW'(1);
                if (rem_q == CW'(1))
                    state_d = HZ_RUN;
            end
            default: begin
                state_d = HZ_RUN;
                rem_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state_q)
                HZ_RUN:  stall = (need != 2'd0);
                HZ_HOLD: stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
        hz.PC_Write    = !stall;
        hz.IF_ID_Write = !stall;
        hz.ID_EX_Flush = stall;
        hz.IF_ID_Flush = !rst && !stall && (state_q == HZ_RUN) &&
                         (hz.ID_Opcode == OPC_BRANCH) && hz.ID_BranchTaken;
    end

    assign dbg_state = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign hz.stall_cycles = stall_cnt;
`endif

endmodule
